octal_to_binary_encoder: RTL and testbench

8-input (octal, one line per digit 0-7) to 3-bit binary encoder with registered outputs. It converts a one-hot digit-select bus into its binary index. It flags an idle (all-zero) input and an illegal multi-hot input, so downstream logic can tell a true digit 0 from no input. It sits between keypad/select-line logic and binary datapath consumers.

---
 rtl/octal_to_binary_encoder.sv | 58 +++++
 tb/tb_octal_to_binary_encoder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/octal_to_binary_encoder.sv
`default_nettype none
// ============================================================================
// octal_to_binary_encoder : registered 8-to-3 encoder with idle/multi-hot flags
// Rev 1.0 - initial release
// ============================================================================
module octal_to_binary_encoder #(
  parameter int HIGH_PRIORITY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid,
  output logic       error
);

  logic [2:0] idx_next;
  logic       any_next;
  logic       multi_next;

  // Clearing the lowest set bit leaves something only when two or more were set.
  always_comb begin
    any_next   = |in;
    multi_next = |(in & (in - 8'd1));
  end

  generate
    if (HIGH_PRIORITY != 0) begin : g_high
      always_comb begin
        idx_next = 3'd0;
        for (int k = 0; k < 8; k++) begin
          if (in[k]) idx_next = 3'(k);
        end
      end
    end else begin : g_low
      always_comb begin
        idx_next = 3'd0;
        for (int k = 7; k >= 0; k--) begin
          if (in[k]) idx_next = 3'(k);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= 3'd0;
      valid <= 1'b0;
      error <= 1'b0;
    end else begin
      out   <= idx_next;
      valid <= any_next;
      error <= multi_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_octal_to_binary_encoder.sv
`default_nettype none
// Bench for octal_to_binary_encoder: both priority modes driven in parallel,
// expectations queued at drive time and checked one cycle later.
module tb_octal_to_binary_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in  = 8'h00;
  logic [2:0] out_hi, out_lo;
  logic       valid_hi, error_hi, valid_lo, error_lo;

  int applied    = 0;
  int miscompare = 0;

  always #5 clk = ~clk;

  octal_to_binary_encoder #(.HIGH_PRIORITY(1)) dut_hi (
    .clk(clk), .rst(rst), .in(in), .out(out_hi), .valid(valid_hi), .error(error_hi)
  );
  octal_to_binary_encoder #(.HIGH_PRIORITY(0)) dut_lo (
    .clk(clk), .rst(rst), .in(in), .out(out_lo), .valid(valid_lo), .error(error_lo)
  );

  typedef struct {
    logic [7:0] in;
    logic       rst;
    logic [2:0] out_hi;
    logic [2:0] out_lo;
    logic       valid;
    logic       error;
  } vec_t;

  vec_t sb[$];
  vec_t table_v[24];

  function automatic vec_t model(input logic [7:0] i, input logic r);
    vec_t e;
    e.in = i; e.rst = r;
    e.out_hi = 3'd0; e.out_lo = 3'd0; e.valid = 1'b0; e.error = 1'b0;
    if (!r) begin
      for (int k = 7; k >= 0; k--) if (i[k]) begin e.out_hi = 3'(k); break; end
      for (int k = 0; k < 8; k++) if (i[k]) begin e.out_lo = 3'(k); break; end
      e.valid = (i != 8'h00);
      e.error = ($countones(i) > 1);
    end
    return e;
  endfunction

  task automatic check_pending();
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      applied++;
      if (out_hi !== e.out_hi || out_lo !== e.out_lo ||
          valid_hi !== e.valid || error_hi !== e.error ||
          valid_lo !== e.valid || error_lo !== e.error) begin
        miscompare++;
        $display("FAIL vec in=%h rst=%b: got hi=%0d lo=%0d v=%b/%b e=%b/%b, want hi=%0d lo=%0d v=%b e=%b",
                 e.in, e.rst, out_hi, out_lo, valid_hi, valid_lo, error_hi, error_lo,
                 e.out_hi, e.out_lo, e.valid, e.error);
      end
    end
  endtask

  task automatic step(input logic [7:0] i, input logic r, input vec_t e);
    @(negedge clk);
    check_pending();
    in  = i;
    rst = r;
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input logic [7:0] i, input logic r, input logic [2:0] h,
                              input logic [2:0] l, input logic v, input logic er);
    vec_t e;
    e.in = i; e.rst = r; e.out_hi = h; e.out_lo = l; e.valid = v; e.error = er;
    return e;
  endfunction

  initial begin
    table_v[0]  = mk(8'hFF, 1, 0, 0, 0, 0);
    table_v[1]  = mk(8'hFF, 1, 0, 0, 0, 0);
    table_v[2]  = mk(8'h00, 0, 0, 0, 0, 0);
    table_v[3]  = mk(8'h01, 0, 0, 0, 1, 0);
    table_v[4]  = mk(8'h02, 0, 1, 1, 1, 0);
    table_v[5]  = mk(8'h04, 0, 2, 2, 1, 0);
    table_v[6]  = mk(8'h08, 0, 3, 3, 1, 0);
    table_v[7]  = mk(8'h10, 0, 4, 4, 1, 0);
    table_v[8]  = mk(8'h20, 0, 5, 5, 1, 0);
    table_v[9]  = mk(8'h40, 0, 6, 6, 1, 0);
    table_v[10] = mk(8'h80, 0, 7, 7, 1, 0);
    table_v[11] = mk(8'h00, 0, 0, 0, 0, 0);
    table_v[12] = mk(8'h01, 0, 0, 0, 1, 0);
    table_v[13] = mk(8'h81, 0, 7, 0, 1, 1);
    table_v[14] = mk(8'h06, 0, 2, 1, 1, 1);
    table_v[15] = mk(8'hFF, 0, 7, 0, 1, 1);
    table_v[16] = mk(8'h10, 0, 4, 4, 1, 0);
    table_v[17] = mk(8'h0C, 0, 3, 2, 1, 1);
    table_v[18] = mk(8'h40, 0, 6, 6, 1, 0);
    table_v[19] = mk(8'h40, 1, 0, 0, 0, 0);
    table_v[20] = mk(8'h40, 0, 6, 6, 1, 0);
    table_v[21] = mk(8'h60, 0, 6, 5, 1, 1);
    table_v[22] = mk(8'h00, 0, 0, 0, 0, 0);
    table_v[23] = mk(8'hFE, 1, 0, 0, 0, 0);

    for (int n = 0; n < 24; n++) step(table_v[n].in, table_v[n].rst, table_v[n]);

    // Reset held several cycles mid-stream, then release on a multi-hot value.
    step(8'h81, 0, model(8'h81, 0));
    step(8'h81, 1, model(8'h81, 1));
    step(8'h18, 1, model(8'h18, 1));
    step(8'h18, 0, model(8'h18, 0));
    step(8'h00, 0, model(8'h00, 0));

    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      logic       r;
      v = 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 15) == 0);
      step(v, r, model(v, r));
    end

    @(negedge clk);
    check_pending();
    if (sb.size() != 0) begin
      miscompare++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompare);
    $finish;
  end

endmodule
`default_nettype wire
